// File: rtl/text_pkg.sv
// Shared constants and state encoding for the text-mode display blocks.
package text_pkg;
  localparam int TEXT_ADDR_W = 10;
  localparam int TEXT_DATA_W = 8;
  localparam int TEXT_COLS = 32;
  localparam int TEXT_ROWS = 32;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_ZERO = 8'h30;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;
endpackage

// File: rtl/text_write_sched_if.sv
// Writer-side and RAM-side signal bundle of the text RAM write scheduler.
interface text_write_sched_if #(
  parameter int N_REQ = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0] i_req_valid;
  logic [N_REQ*ADDR_W-1:0] i_req_addr;
  logic [N_REQ*DATA_W-1:0] i_req_data;
  logic [N_REQ-1:0] o_req_ready;
  logic i_clear;
  logic o_clear_busy;
  logic o_we;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_data;

  modport master (
    output i_req_valid, i_req_addr, i_req_data, i_clear,
    input o_req_ready, o_clear_busy, o_we, o_address, o_data
  );

  modport slave (
    input i_req_valid, i_req_addr, i_req_data, i_clear,
    output o_req_ready, o_clear_busy, o_we, o_address, o_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; the last winner drops to lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic             mask,
  output logic [N_REQ-1:0] grant
);
  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    int idx;
    idx = 0;
    cand = '0;
    gidx = ptr_q;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      cand = PTR_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        gidx = cand;
      end
    end
    if (found && !mask) grant[gidx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && |grant) begin
      if (gidx == PTR_W'(N_REQ - 1)) ptr_d = '0;
      else ptr_d = gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/text_write_sched.sv
// Shares the text RAM write port among N writers and runs screen clears.
module text_write_sched
  import text_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ADDR_W = TEXT_ADDR_W,
  parameter int DATA_W = TEXT_DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_CHAR = CHAR_SPACE,
  parameter int N_CELLS = 1024
) (
  input logic i_clk,
  input logic i_reset,
  text_write_sched_if.slave bus
);
  localparam int CNT_W = $clog2(N_CELLS) + 1;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [N_REQ-1:0] grant;
  logic mask;
  logic accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign mask = i_reset | bus.i_clear | (state_q == ST_CLEAR);
  assign accept = |grant;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk    (i_clk),
    .rst    (i_reset),
    .req    (bus.i_req_valid),
    .advance(accept),
    .mask   (mask),
    .grant  (grant)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_addr = bus.i_req_addr[k*ADDR_W +: ADDR_W];
        sel_data = bus.i_req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Outputs are registered one cycle ahead, so cnt_q runs one past the
  // address currently on the port; the sweep ends once it reaches N_CELLS.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = 1'b0;
    busy_d = busy_q;
    addr_d = addr_q;
    data_d = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_clear) begin
          state_d = ST_CLEAR;
          busy_d = 1'b1;
          we_d = 1'b1;
          addr_d = '0;
          data_d = CLEAR_CHAR;
          cnt_d = CNT_W'(1);
        end else if (accept) begin
          we_d = 1'b1;
          addr_d = sel_addr;
          data_d = sel_data;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_W'(N_CELLS)) begin
          state_d = ST_IDLE;
          busy_d = 1'b0;
          cnt_d = '0;
        end else begin
          we_d = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          data_d = CLEAR_CHAR;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      busy_q <= busy_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign bus.o_req_ready = grant;
  assign bus.o_clear_busy = busy_q;
  assign bus.o_we = we_q;
  assign bus.o_address = addr_q;
  assign bus.o_data = data_q;
endmodule

// File: tb/tb_text_write_sched.sv
// Directed bench for the text RAM write scheduler.
module tb_text_write_sched;
  localparam int N = 4;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk;
  logic rst;
  int checks;
  int failures;

  text_write_sched_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  text_write_sched #(.N_REQ(N), .N_CELLS(1024)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.i_req_addr[k*AW +: AW] = a;
    bus.i_req_data[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    bus.i_req_valid = '0;
    bus.i_clear = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_req_valid = 4'b1111;
    bus.i_clear = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (bus.o_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_we got=%b want=0", bus.o_we);
    end
    checks++;
    if (bus.o_clear_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", bus.o_clear_busy);
    end
    checks++;
    if (bus.o_address !== 10'h000 || bus.o_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_addr_data got=%h/%h want=000/00",
               bus.o_address, bus.o_data);
    end
    checks++;
    if (bus.o_req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got=%b want=0000", bus.o_req_ready);
    end
    bus.i_req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_req(1, 10'h063, 8'h31);
    bus.i_req_valid = 4'b0010;
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL single_ready got=%b want=0010", bus.o_req_ready);
    end
    tick();
    bus.i_req_valid = '0;
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_address !== 10'h063 ||
        bus.o_data !== 8'h31) begin
      failures++;
      $display("FAIL single_write got=%b/%h/%h want=1/063/31",
               bus.o_we, bus.o_address, bus.o_data);
    end
    tick();
    checks++;
    if (bus.o_we !== 1'b0) begin
      failures++;
      $display("FAIL single_we_drop got=%b want=0", bus.o_we);
    end
  endtask

  task automatic test_fairness();
    int cnt [N];
    logic [N-1:0] exp_g;
    int prev;
    do_reset();
    for (int k = 0; k < N; k++) begin
      cnt[k] = 0;
      set_req(k, AW'(10'h100 + k), DW'(8'h41 + k));
    end
    bus.i_req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_g = 4'b0001 << (i % 4);
      checks++;
      if (bus.o_req_ready !== exp_g) begin
        failures++;
        $display("FAIL fair_grant%0d got=%b want=%b", i,
                 bus.o_req_ready, exp_g);
      end
      for (int k = 0; k < N; k++) if (bus.o_req_ready[k]) cnt[k]++;
      prev = i % 4;
      tick();
      checks++;
      if (bus.o_we !== 1'b1 || bus.o_address !== AW'(10'h100 + prev) ||
          bus.o_data !== DW'(8'h41 + prev)) begin
        failures++;
        $display("FAIL fair_write%0d got=%b/%h/%h want=1/%h/%h", i,
                 bus.o_we, bus.o_address, bus.o_data,
                 AW'(10'h100 + prev), DW'(8'h41 + prev));
      end
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (cnt[k] != 2) begin
        failures++;
        $display("FAIL fair_count%0d got=%0d want=2", k, cnt[k]);
      end
    end
    bus.i_req_valid = '0;
    tick();
  endtask

  task automatic test_wrap_skip();
    do_reset();
    set_req(1, 10'h011, 8'h61);
    set_req(2, 10'h022, 8'h62);
    set_req(3, 10'h033, 8'h63);
    bus.i_req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_first got=%b want=0100", bus.o_req_ready);
    end
    tick();
    bus.i_req_valid = 4'b1010;
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_grant3 got=%b want=1000", bus.o_req_ready);
    end
    tick();
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_address !== 10'h033) begin
      failures++;
      $display("FAIL wrap_write3 got=%b/%h want=1/033",
               bus.o_we, bus.o_address);
    end
    checks++;
    if (bus.o_req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_grant1 got=%b want=0010", bus.o_req_ready);
    end
    tick();
    bus.i_req_valid = '0;
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_address !== 10'h011 ||
        bus.o_data !== 8'h61) begin
      failures++;
      $display("FAIL wrap_write1 got=%b/%h/%h want=1/011/61",
               bus.o_we, bus.o_address, bus.o_data);
    end
    tick();
  endtask

  task automatic test_clear();
    int n;
    int bad;
    set_req(0, 10'h3AB, 8'h7A);
    bus.i_req_valid = 4'b0001;
    bus.i_clear = 1'b1;
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL clear_entry_ready got=%b want=0000", bus.o_req_ready);
    end
    tick();
    bus.i_clear = 1'b0;
    n = 0;
    bad = 0;
    while (bus.o_clear_busy === 1'b1 && n < 1100) begin
      #1;
      if (bad == 0 && (bus.o_we !== 1'b1 || bus.o_address !== AW'(n) ||
          bus.o_data !== 8'h20 || bus.o_req_ready !== 4'b0000)) begin
        bad = 1;
        $display("FAIL clear_sweep at=%0d got=%b/%h/%h/%b want=1/%h/20/0000",
                 n, bus.o_we, bus.o_address, bus.o_data,
                 bus.o_req_ready, AW'(n));
      end
      n++;
      tick();
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (n != 1024) begin
      failures++;
      $display("FAIL clear_len got=%0d want=1024", n);
    end
    #1;
    checks++;
    if (bus.o_we !== 1'b0 || bus.o_req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL clear_exit got=%b/%b want=0/0001",
               bus.o_we, bus.o_req_ready);
    end
    tick();
    bus.i_req_valid = '0;
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_address !== 10'h3AB ||
        bus.o_data !== 8'h7A) begin
      failures++;
      $display("FAIL clear_after_write got=%b/%h/%h want=1/3ab/7a",
               bus.o_we, bus.o_address, bus.o_data);
    end
    tick();
  endtask

  task automatic test_clear_pending();
    int n;
    set_req(2, 10'h2AA, 8'h55);
    bus.i_req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL pend_accept got=%b want=0100", bus.o_req_ready);
    end
    tick();
    bus.i_req_valid = '0;
    bus.i_clear = 1'b1;
    #1;
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_address !== 10'h2AA ||
        bus.o_data !== 8'h55 || bus.o_clear_busy !== 1'b0) begin
      failures++;
      $display("FAIL pend_write got=%b/%h/%h/%b want=1/2aa/55/0",
               bus.o_we, bus.o_address, bus.o_data, bus.o_clear_busy);
    end
    tick();
    bus.i_clear = 1'b0;
    checks++;
    if (bus.o_clear_busy !== 1'b1 || bus.o_we !== 1'b1 ||
        bus.o_address !== 10'h000 || bus.o_data !== 8'h20) begin
      failures++;
      $display("FAIL pend_sweep_start got=%b/%b/%h/%h want=1/1/000/20",
               bus.o_clear_busy, bus.o_we, bus.o_address, bus.o_data);
    end
    n = 0;
    while (bus.o_clear_busy === 1'b1 && n < 1100) begin
      n++;
      tick();
    end
    checks++;
    if (n != 1024) begin
      failures++;
      $display("FAIL pend_sweep_len got=%0d want=1024", n);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    n = 0;
    while (!(bus.o_clear_busy === 1'b1 && bus.o_address === 10'd500) &&
           n < 1100) begin
      n++;
      tick();
    end
    checks++;
    if (n >= 1100) begin
      failures++;
      $display("FAIL midclr_reach got=timeout want=addr500");
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.o_we !== 1'b0 || bus.o_clear_busy !== 1'b0) begin
      failures++;
      $display("FAIL midclr_abort got=%b/%b want=0/0",
               bus.o_we, bus.o_clear_busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.o_we !== 1'b0 || bus.o_clear_busy !== 1'b0) begin
      failures++;
      $display("FAIL midclr_idle got=%b/%b want=0/0",
               bus.o_we, bus.o_clear_busy);
    end
    set_req(1, 10'h145, 8'h39);
    set_req(3, 10'h3FF, 8'h3A);
    bus.i_req_valid = 4'b1010;
    #1;
    checks++;
    if (bus.o_req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL midclr_ptr got=%b want=0010", bus.o_req_ready);
    end
    tick();
    bus.i_req_valid = '0;
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_address !== 10'h145 ||
        bus.o_data !== 8'h39) begin
      failures++;
      $display("FAIL midclr_write got=%b/%h/%h want=1/145/39",
               bus.o_we, bus.o_address, bus.o_data);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_addr = '0;
    bus.i_req_data = '0;
    bus.i_clear = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap_skip();
    test_clear();
    test_clear_pending();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
